axil_reg_master: RTL and testbench
==================================

Name: axil_reg_master

Overview:
AXI4-Lite initiator that turns single register commands into transactions on a slave port such as hravframework's S_AXI.
- Host side (test sequencer, MicroBlaze shim or bring-up FSM) issues one read or write through a valid/ready command port.
- Block drives the AW/W/B/AR/R channels and returns data plus response on a valid/ready response port.
- One transaction outstanding at a time; fully synchronous to axi_aclk.

Parameters:
C_ADDR_WIDTH, 32, command and M_AXI address width
C_DATA_WIDTH, 32, data width; fixed at 32 (strobe width C_DATA_WIDTH/8)
C_BASEADDR, 32'h11000000, added to cmd_addr to form M_AXI_AWADDR/ARADDR (modulo 2^C_ADDR_WIDTH)
C_TIMEOUT_CYCLES, 1024, watchdog limit; used only with AXIL_TIMEOUT_EN

Ports:
axi_aclk  in  1  sole clock
axi_reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  32  register offset
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write byte strobes
rsp_valid  out  1  response held
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data; 0 for writes
rsp_resp  out  2  BRESP or RRESP, or 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by watchdog
M_AXI_AWADDR  out  32  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobes
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  32  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset values: all outputs 0, including all VALID/READY outputs, address, data and strobes. State = IDLE. Reset is asynchronous and may arrive mid-transaction; the block drops all valids immediately and the pending command is lost.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - cmd_ready = 1 only in IDLE with rsp_valid = 0.
  - On cmd_valid & cmd_ready, register address = cmd_addr + C_BASEADDR, plus wdata and wstrb.
  - Write command: next cycle assert AWVALID and WVALID together, go to WRITE.
  - Read command: next cycle assert ARVALID, go to READ.
- WRITE:
  - AW and W complete independently. Drop AWVALID the cycle after AWREADY is seen; same for WVALID/WREADY.
  - Sticky aw_done and w_done flags record each completion. Both handshakes in one cycle is legal.
  - When both flags are set, assert BREADY and go to WRESP.
  - Payload stays stable while its valid is high.
- WRESP:
  - BREADY = 1. On BVALID, capture BRESP; rsp_rdata = 0; go to RESP.
- READ:
  - Hold ARVALID until ARREADY. Then drop ARVALID, raise RREADY, go to RDATA.
- RDATA:
  - RREADY = 1. On RVALID, capture RDATA and RRESP; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable.
  - On rsp_ready, clear rsp_valid and return to IDLE. cmd_ready rises on the following cycle, so back-to-back commands are spaced by at least one idle cycle.
- Minimum latency, zero-wait slave:
  - Write: cmd accept at cycle 0, AW/W valid at 1, BREADY at 2, BVALID seen at 2, rsp_valid at 3.
  - Read: ARVALID at 1, RDATA captured at 2, rsp_valid at 3.
- No VALID is ever deasserted before its READY. No READY is asserted outside its state.
- The address adder wraps modulo 2^32 with no error.

Optional Feature:
AXIL_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WRITE or READ and increments every cycle in WRITE, WRESP, READ and RDATA.
  - When it reaches C_TIMEOUT_CYCLES, drop all M_AXI valids and readies and go to RESP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - If a completing handshake coincides with the limit cycle, the handshake wins: normal response, rsp_timeout = 0.
- Undefined: no counter is built, rsp_timeout is tied to 0, and the block waits indefinitely.

Test Plan:
- Write, zero-wait slave, cmd_addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> AWADDR 0x11000010 and WDATA 0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_resp 0, rsp_rdata 0.
- Write where slave gives WREADY 2 cycles before AWREADY, then BVALID 3 cycles later -> WVALID drops after its handshake while AWVALID stays high until accepted; exactly one B handshake; rsp_resp equals BRESP (drive 2'b00).
- Read of 0x24, slave RDATA 0x12345678, RRESP 2'b00, RVALID delayed 5 cycles -> ARADDR 0x11000024; ARVALID held until ARREADY; rsp_rdata 0x12345678.
- Response backpressure: rsp_ready held low 4 cycles, cmd_valid held high -> rsp fields stable; cmd_ready stays 0 until the cycle after rsp_ready; the second command is then issued.
- Reset asserted while in WRITE with AWVALID high -> AWVALID, WVALID and rsp_valid go to 0 without waiting for a clock edge; after reset release the state is IDLE with cmd_ready = 1.
- With AXIL_TIMEOUT_EN, C_TIMEOUT_CYCLES = 16, slave never asserts ARREADY -> at count 16, ARVALID drops; rsp_valid with rsp_resp 2'b10 and rsp_timeout 1.

Source files
------------

// File: rtl/axil_reg_master.sv
// AXI4-Lite register initiator: one host command in, one AXI-Lite transaction out, one response back.
// Optional watchdog built only when AXIL_TIMEOUT_EN is defined.
module axil_reg_master #(
    parameter int                      C_ADDR_WIDTH     = 32,
    parameter int                      C_DATA_WIDTH     = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASEADDR       = 32'h11000000,
    parameter int                      C_TIMEOUT_CYCLES = 1024
) (
    input  logic                      axi_aclk,
    input  logic                      axi_reset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,

    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    if (C_DATA_WIDTH != 32 || C_TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("axil_reg_master: C_DATA_WIDTH must be 32 and C_TIMEOUT_CYCLES at least 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        accept;
    logic                        capture_b, capture_r, timeout_hit;
    logic [C_ADDR_WIDTH-1:0]     addr_q;
    logic [C_DATA_WIDTH-1:0]     wdata_q;
    logic [C_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [C_DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                  rsp_resp_q;
    logic                        rsp_tmo_q;

    // Handshake outputs decode straight from state so an async reset drops them at once.
    assign cmd_ready     = (state_q == IDLE) && !axi_reset;
    assign rsp_valid     = (state_q == RESP);
    assign M_AXI_AWVALID = (state_q == WRITE) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == WRITE) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WRESP);
    assign M_AXI_ARVALID = (state_q == READ);
    assign M_AXI_RREADY  = (state_q == RDATA);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign accept        = cmd_valid && cmd_ready;

`ifdef AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             busy;

    assign busy        = (state_q == WRITE) || (state_q == WRESP) ||
                         (state_q == READ)  || (state_q == RDATA);
    assign rsp_timeout = rsp_tmo_q;

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        capture_b   = 1'b0;
        capture_r   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (accept) state_d = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = WRESP;
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    capture_b = 1'b1;
                    state_d   = RESP;
                end
            end
            READ: begin
                if (M_AXI_ARREADY) state_d = RDATA;
            end
            RDATA: begin
                if (M_AXI_RVALID) begin
                    capture_r = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXIL_TIMEOUT_EN
        // Watchdog only fires when no handshake moved the FSM this cycle.
        if (busy && cnt_q == CNT_W'(C_TIMEOUT_CYCLES - 1) && state_d == state_q) begin
            timeout_hit = 1'b1;
            state_d     = RESP;
        end
`endif
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_tmo_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr + C_BASEADDR;
                wdata_q <= cmd_write ? cmd_wdata : '0;
                wstrb_q <= cmd_write ? cmd_wstrb : '0;
            end
            if (capture_b) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= M_AXI_BRESP;
                rsp_tmo_q   <= 1'b0;
            end else if (capture_r) begin
                rsp_rdata_q <= M_AXI_RDATA;
                rsp_resp_q  <= M_AXI_RRESP;
                rsp_tmo_q   <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= 2'b10;
                rsp_tmo_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master: scripted slave, response scoreboard, immediate-assert checks.
module tb_axil_reg_master;

    logic        clk = 1'b0;
    logic        axi_reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   b_hs  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (bvalid && bready) b_hs <= b_hs + 1;

    axil_reg_master #(.C_TIMEOUT_CYCLES(16)) dut (
        .axi_aclk(clk), .axi_reset(axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [1:0] r, input logic t);
        rsp_t e;
        e.rdata = d;
        e.resp  = r;
        e.tmo   = t;
        sb.push_back(e);
    endtask

    task automatic cmp_rsp(input string tag);
        rsp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_resp"}, 32'(rsp_resp), 32'(e.resp));
            chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.tmo));
        end
    endtask

    task automatic take_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        cmp_rsp(tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int b0;
        int n;
        axi_reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

        // Reset state
        #3;
        chk("reset_outputs_zero", 32'(|{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
            awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready}), 32'd0);
        tick(); tick();
        axi_reset = 1'b0;
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        expect_rsp(32'h0, 2'b00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("w1_awvalid", 32'(awvalid), 32'd1);
        chk("w1_wvalid", 32'(wvalid), 32'd1);
        chk("w1_awaddr", awaddr, 32'h11000010);
        chk("w1_wdata", wdata, 32'hDEADBEEF);
        chk("w1_wstrb", 32'(wstrb), 32'hF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("w1_bready_c2", 32'(bready), 32'd1);
        chk("w1_aw_dropped", 32'({awvalid, wvalid}), 32'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("w1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
        chk("w1_bready_off", 32'(bready), 32'd0);
        take_rsp("w1");

        // Write with WREADY two cycles before AWREADY, late BVALID
        b0 = b_hs;
        issue(1'b1, 32'h20, 32'hA5A50001, 4'h3);
        expect_rsp(32'h0, 2'b00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("w2_wvalid_dropped", 32'(wvalid), 32'd0);
        chk("w2_awvalid_held", 32'(awvalid), 32'd1);
        chk("w2_wstrb", 32'(wstrb), 32'h3);
        tick();
        chk("w2_awvalid_held2", 32'(awvalid), 32'd1);
        chk("w2_awaddr_stable", awaddr, 32'h11000020);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("w2_awvalid_dropped", 32'(awvalid), 32'd0);
        chk("w2_bready", 32'(bready), 32'd1);
        tick(); tick();
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("w2_rsp_valid", 32'(rsp_valid), 32'd1);
        take_rsp("w2");
        chk("w2_one_b_handshake", 32'(b_hs - b0), 32'd1);

        // Read with ARREADY late and RVALID delayed five cycles
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        expect_rsp(32'h12345678, 2'b00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("r1_araddr", araddr, 32'h11000024);
        chk("r1_arvalid", 32'(arvalid), 32'd1);
        chk("r1_rready_off", 32'(rready), 32'd0);
        tick(); tick();
        chk("r1_arvalid_held", 32'(arvalid), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r1_arvalid_dropped", 32'(arvalid), 32'd0);
        chk("r1_rready", 32'(rready), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("r1_rready_wait", 32'(rready), 32'd1);
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = '0;
        take_rsp("r1");

        // Zero-wait read with address wrap and error response
        issue(1'b0, 32'hFFFFFFF0, 32'h0, 4'h0);
        expect_rsp(32'h0BADF00D, 2'b11, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("r2_araddr_wrap", araddr, 32'h10FFFFF0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b11;
        tick();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        chk("r2_rsp_valid_c3", 32'(rsp_valid), 32'd1);
        take_rsp("r2");

        // Response backpressure with a second command waiting
        issue(1'b1, 32'h30, 32'h00000055, 4'hF);
        expect_rsp(32'h0, 2'b10, 1'b0);
        tick();
        issue(1'b0, 32'h40, 32'h0, 4'h0);
        chk("bp_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_resp_hold", 32'(rsp_resp), 32'd2);
            chk("bp_rsp_rdata_hold", rsp_rdata, 32'd0);
            chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
            tick();
        end
        chk("bp_cmd_ready_low_at_ready", 32'(cmd_ready), 32'd0);
        cmp_rsp("bp1");
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);
        expect_rsp(32'hCAFEF00D, 2'b00, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("bp2_arvalid", 32'(arvalid), 32'd1);
        chk("bp2_araddr", araddr, 32'h11000040);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        rvalid = 1'b0; rdata = '0;
        take_rsp("bp2");

        // Asynchronous reset in the middle of a write
        issue(1'b1, 32'h50, 32'h11112222, 4'hF);
        tick();
        cmd_valid = 1'b0;
        chk("rst_awvalid_before", 32'(awvalid), 32'd1);
        #2;
        axi_reset = 1'b1;
        #1;
        chk("rst_awvalid_async", 32'(awvalid), 32'd0);
        chk("rst_wvalid_async", 32'(wvalid), 32'd0);
        chk("rst_rsp_valid_async", 32'(rsp_valid), 32'd0);
        chk("rst_awaddr_async", awaddr, 32'd0);
        @(posedge clk);
        #1;
        axi_reset = 1'b0;
        tick();
        chk("rst_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_idle_awvalid", 32'(awvalid), 32'd0);

`ifdef AXIL_TIMEOUT_EN
        // Slave never accepts the read address
        issue(1'b0, 32'h60, 32'h0, 4'h0);
        expect_rsp(32'h0, 2'b10, 1'b1);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (arvalid && n < 100) begin
            n++;
            tick();
        end
        chk("tmo_arvalid_cycles", 32'(n), 32'd16);
        chk("tmo_arvalid_dropped", 32'(arvalid), 32'd0);
        chk("tmo_rready_off", 32'(rready), 32'd0);
        take_rsp("tmo");
`else
        n = 0;
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
